fifo_in_arb: RTL and testbench

- Round-robin arbiter that shares the single write port of an async FIFO (DIPULL/DIPUSH/DIN style) among N producers in the FIFO's write-clock domain.
- Grants one producer at a time for a burst of up to BURST words.
- Gates that producer's pull by the FIFO's DIPULL back-pressure and forwards accepted words to the FIFO through one register stage.
- Releases the grant on burst end, request drop or idle timeout.

---
 rtl/fifo_in_arb.sv | 155 +++++++++++++++
 tb/tb_fifo_in_arb.sv | 135 +++++++++++++
 2 files changed

// File: rtl/fifo_in_arb.sv
// fifo_in_arb: round-robin arbiter sharing one async-FIFO write port among
// N producers. One producer is granted for up to BURST words. Its pull is
// gated by FIFO back-pressure, and accepted words reach the FIFO one cycle later.

// Per-producer pull gating and misuse detection.
module fifo_in_arb_lane (
  input  logic sel,
  input  logic pull_ok,
  input  logic push,
  output logic pull,
  output logic bad
);
  assign pull = sel & pull_ok;
  // A push without our pull is a protocol violation; the word is dropped.
  assign bad  = push & ~pull;
endmodule

module fifo_in_arb #(
  parameter int BW    = 32,
  parameter int N     = 4,
  parameter int BURST = 8,
  parameter int TMO   = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N-1:0]         SRC_REQ,
  output logic [N-1:0]         SRC_PULL,
  input  logic [N-1:0]         SRC_PUSH,
  input  logic [N*BW-1:0]      SRC_DIN,
  input  logic                 FIFO_PULL,
  output logic                 FIFO_PUSH,
  output logic [BW-1:0]        FIFO_DIN,
  output logic                 GNT_VLD,
  output logic [$clog2(N)-1:0] GNT_ID,
  output logic                 ERR
);
  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_REL} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] rr, rr_nxt, gnt_id_nxt, pick, cur;
  logic [7:0]    cnt, cnt_nxt, tmo_cnt, tmo_nxt;
  logic          gnt_vld_nxt, found, pull_ok, accept, req_gnt;
  logic [N-1:0]  gsel, bad;
  logic [BW-1:0] gnt_din;

  assign pull_ok = (state == S_GRANT) & FIFO_PULL & (cnt < 8'(BURST));

  generate
    for (genvar g = 0; g < N; g++) begin : g_lane
      assign gsel[g] = (GNT_ID == IW'(g));
      fifo_in_arb_lane u_lane (
        .sel    (gsel[g]),
        .pull_ok(pull_ok),
        .push   (SRC_PUSH[g]),
        .pull   (SRC_PULL[g]),
        .bad    (bad[g])
      );
    end
  endgenerate

  // Only the granted lane can pull, so any pull&push is the accept.
  assign accept  = |(SRC_PULL & SRC_PUSH);
  assign req_gnt = |(SRC_REQ & gsel);

  // Select the granted producer's word.
  always_comb begin
    gnt_din = '0;
    for (int i = 0; i < N; i++)
      if (gsel[i]) gnt_din = SRC_DIN[i*BW +: BW];
  end

  // Round-robin pick: first requester at or after rr, wrapping at N-1.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cur   = rr;
    for (int k = 0; k < N; k++) begin
      if (!found && SRC_REQ[cur]) begin
        found = 1'b1;
        pick  = cur;
      end
      cur = (cur == IW'(N-1)) ? '0 : cur + 1'b1;
    end
  end

  // Grant FSM next state: arbitrate, count burst/idle, release.
  always_comb begin
    state_nxt   = state;
    rr_nxt      = rr;
    gnt_id_nxt  = GNT_ID;
    gnt_vld_nxt = GNT_VLD;
    cnt_nxt     = cnt;
    tmo_nxt     = tmo_cnt;
    case (state)
      S_IDLE: begin
        if (found) begin
          gnt_id_nxt  = pick;
          gnt_vld_nxt = 1'b1;
          cnt_nxt     = '0;
          tmo_nxt     = '0;
          state_nxt   = S_GRANT;
        end
      end
      S_GRANT: begin
        if (accept) begin
          cnt_nxt = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
          tmo_nxt = '0;
        end else if (FIFO_PULL && tmo_cnt < 8'(TMO)) begin
          tmo_nxt = tmo_cnt + 8'd1;
        end
        if (cnt_nxt >= 8'(BURST) || (!req_gnt && !accept) || tmo_nxt >= 8'(TMO)) begin
          state_nxt   = S_REL;
          gnt_vld_nxt = 1'b0;
          rr_nxt      = (GNT_ID == IW'(N-1)) ? '0 : GNT_ID + 1'b1;
        end
      end
      S_REL:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Grant FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      rr      <= '0;
      cnt     <= '0;
      tmo_cnt <= '0;
      GNT_VLD <= 1'b0;
      GNT_ID  <= '0;
    end else begin
      state   <= state_nxt;
      rr      <= rr_nxt;
      cnt     <= cnt_nxt;
      tmo_cnt <= tmo_nxt;
      GNT_VLD <= gnt_vld_nxt;
      GNT_ID  <= gnt_id_nxt;
    end
  end

  // Output register toward the FIFO plus sticky protocol error.
  always_ff @(posedge CLK) begin
    if (RST) begin
      FIFO_PUSH <= 1'b0;
      FIFO_DIN  <= '0;
      ERR       <= 1'b0;
    end else begin
      FIFO_PUSH <= accept;
      if (accept) FIFO_DIN <= gnt_din;
      if (|bad) ERR <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_in_arb.sv
// Randomized bench for fifo_in_arb against a behavioural grant/burst model.
module tb_fifo_in_arb;
  localparam int BW = 32, N = 4, BURST = 8, TMO = 16, IW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          RST;
  logic [N-1:0]  SRC_REQ, SRC_PULL, SRC_PUSH;
  logic [N*BW-1:0] SRC_DIN;
  logic          FIFO_PULL, FIFO_PUSH, GNT_VLD, ERR;
  logic [BW-1:0] FIFO_DIN;
  logic [IW-1:0] GNT_ID;

  fifo_in_arb #(.BW(BW), .N(N), .BURST(BURST), .TMO(TMO)) dut (
    .CLK(clk), .RST(RST), .SRC_REQ(SRC_REQ), .SRC_PULL(SRC_PULL),
    .SRC_PUSH(SRC_PUSH), .SRC_DIN(SRC_DIN), .FIFO_PULL(FIFO_PULL),
    .FIFO_PUSH(FIFO_PUSH), .FIFO_DIN(FIFO_DIN), .GNT_VLD(GNT_VLD),
    .GNT_ID(GNT_ID), .ERR(ERR)
  );

  int errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: who holds the grant, words/idle so far, dead cycles left.
  bit          m_gnt, m_err, m_push;
  int          m_id, m_words, m_idle, m_rr, m_dead;
  logic [31:0] m_din;
  logic [N-1:0] m_pull;
  int          order[$];
  bit          prev_vld = 1'b0;

  task automatic model_reset();
    m_gnt = 0; m_err = 0; m_push = 0; m_din = '0;
    m_id = 0; m_words = 0; m_idle = 0; m_rr = 0; m_dead = 0;
  endtask

  task automatic model_step();
    bit acc, hit;
    if (RST) begin
      model_reset();
      return;
    end
    acc = |(m_pull & SRC_PUSH);
    if (|(SRC_PUSH & ~m_pull)) m_err = 1;
    m_push = acc;
    if (acc) m_din = SRC_DIN[m_id*BW +: BW];
    if (m_gnt) begin
      if (acc) begin m_words++; m_idle = 0; end
      else if (FIFO_PULL && m_idle < TMO) m_idle++;
      if (m_words == BURST || (!SRC_REQ[m_id] && !acc) || m_idle == TMO) begin
        m_gnt = 0; m_rr = (m_id + 1) % N; m_dead = 1;
      end
    end else if (m_dead > 0) begin
      m_dead--;
    end else if (SRC_REQ != '0) begin
      hit = 0;
      for (int k = 0; k < N; k++)
        if (!hit && SRC_REQ[(m_rr + k) % N]) begin hit = 1; m_id = (m_rr + k) % N; end
      m_gnt = 1; m_words = 0; m_idle = 0;
    end
  endtask

  task automatic cycle(input int req_pct, input int pull_pct, input int push_pct,
                       input int bad_pct, input int rst_pct);
    @(negedge clk);
    chk("gnt_vld", 32'(GNT_VLD), 32'(m_gnt));
    chk("gnt_id", 32'(GNT_ID), 32'(m_id));
    chk("fifo_push", 32'(FIFO_PUSH), 32'(m_push));
    chk("fifo_din", FIFO_DIN, m_din);
    chk("err", 32'(ERR), 32'(m_err));
    if (GNT_VLD && !prev_vld) order.push_back(int'(GNT_ID));
    prev_vld = GNT_VLD;
    RST = ($urandom_range(99) < rst_pct);
    FIFO_PULL = ($urandom_range(99) < pull_pct);
    for (int i = 0; i < N; i++) begin
      SRC_REQ[i] = ($urandom_range(99) < req_pct);
      SRC_DIN[i*BW +: BW] = $urandom;
    end
    m_pull = (m_gnt && FIFO_PULL && m_words < BURST) ? N'(1 << m_id) : '0;
    for (int i = 0; i < N; i++)
      SRC_PUSH[i] = m_pull[i] ? ($urandom_range(99) < push_pct)
                              : ($urandom_range(99) < bad_pct);
    #1;
    chk("src_pull", 32'(SRC_PULL), 32'(m_pull));
    model_step();
  endtask

  // req%, pull%, push-when-pulled%, stray-push%, reset%, cycles
  int ph[5][6] = '{
    '{100,  50, 100, 0, 0, 150},
    '{100, 100,   0, 0, 0, 150},
    '{ 70,  80,  70, 0, 0, 300},
    '{ 90,  90,  80, 3, 0, 200},
    '{ 80,  80,  80, 1, 3, 300}
  };

  initial begin
    RST = 1'b1; SRC_REQ = '0; SRC_PUSH = '0; SRC_DIN = '0; FIFO_PULL = 1'b0;
    model_reset();
    m_pull = '0;
    repeat (2) @(posedge clk);
    repeat (3) cycle(100, 100, 100, 0, 100);

    // All producers requesting, FIFO always ready: plain rotation.
    order.delete();
    repeat (60) cycle(100, 100, 100, 0, 0);
    chk("order_len_ge5", 32'(order.size() >= 5), 32'd1);
    if (order.size() >= 5)
      for (int k = 0; k < 5; k++) chk("order", 32'(order[k]), 32'(k % N));

    for (int p = 0; p < 5; p++)
      repeat (ph[p][5]) cycle(ph[p][0], ph[p][1], ph[p][2], ph[p][3], ph[p][4]);

    // Final reset then a clean rotation restart from producer 0.
    repeat (2) cycle(100, 100, 100, 0, 100);
    order.delete();
    repeat (25) cycle(100, 100, 100, 0, 0);
    chk("restart_len_ge2", 32'(order.size() >= 2), 32'd1);
    if (order.size() >= 2) begin
      chk("restart_first", 32'(order[0]), 32'd0);
      chk("restart_second", 32'(order[1]), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
